// File: rtl/vehicle_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// vehicle_sensor_conditioner
//
// Purpose:
//   Turns two raw, asynchronous inductive-loop detector levels (main road and
//   side road) into clean vehicle-demand signals for a traffic light
//   controller. Each channel is synchronized, debounced, stretched by a hold
//   period after the vehicle leaves, watched for a stuck detector, and counts
//   qualified vehicle arrivals. The two channels are identical and share no
//   state apart from the common counter clear.
//
// Ports:
//   clk            in   1  single clock, rising edge
//   rst            in   1  asynchronous active-high reset
//   main_loop_raw  in   1  raw main-road loop level (asynchronous)
//   side_loop_raw  in   1  raw side-road loop level (asynchronous)
//   cnt_clr        in   1  synchronous clear of both arrival counters
//   main_sensor    out  1  conditioned main-road demand
//   side_sensor    out  1  conditioned side-road demand
//   main_fault     out  1  main loop stuck-detector flag
//   side_fault     out  1  side loop stuck-detector flag
//   main_count     out  8  saturating main-road arrival count
//   side_count     out  8  saturating side-road arrival count
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// vsc_channel: one conditioning channel.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   i_raw        raw loop level (asynchronous)
//   i_cnt_clr    synchronous clear of the arrival counter
//   o_sensor     conditioned demand (PRESENT, HOLD or FAULT)
//   o_fault      stuck-detector flag (FAULT)
//   o_count      saturating arrival count
// -----------------------------------------------------------------------------
module vsc_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int STUCK_CYCLES    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_raw,
    input  logic       i_cnt_clr,
    output logic       o_sensor,
    output logic       o_fault,
    output logic [7:0] o_count
);

    // Terminal values of the three counters. The debounce count is loaded
    // with 1 by the IDLE sample, so QUALIFY finishes when it already holds
    // DEBOUNCE_CYCLES-1 and sees one more high sample. The hold count is
    // loaded with 1 on entry and the sample that finds it at HOLD_CYCLES
    // is the HOLD_CYCLES-th low sample spent inside HOLD.
    localparam logic [3:0]  DEB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES);
    localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUALIFY,
        ST_PRESENT,
        ST_HOLD,
        ST_FAULT
    } state_t;

    logic        r_sync1;
    logic        r_sync2;
    state_t      r_state;
    logic [3:0]  r_deb;
    logic [7:0]  r_hold;
    logic [15:0] r_stuck;
    logic [7:0]  r_count;

    state_t      w_state_nxt;
    logic [3:0]  w_deb_nxt;
    logic [7:0]  w_hold_nxt;
    logic [15:0] w_stuck_nxt;
    logic        w_arrival;
    logic        w_s;

    assign w_s = r_sync2;

    // Two-flop synchronizer; the FSM never looks at i_raw directly.
    // Clearing it in reset means a loop that is high throughout reset still
    // has to requalify from scratch after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its source; with blocking
            // assignments r_sync2 would copy the new r_sync1 and the
            // synchronizer would collapse to a single stage.
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State and counter registers. Every counter is cleared by the
    // asynchronous reset so the outputs drop the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_deb   <= 4'd0;
            r_hold  <= 8'd0;
            r_stuck <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_deb   <= w_deb_nxt;
            r_hold  <= w_hold_nxt;
            r_stuck <= w_stuck_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        // NOTE: every signal written here gets a default before the case;
        // any path that skipped an assignment would otherwise infer a latch.
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb;
        w_hold_nxt  = r_hold;
        w_stuck_nxt = r_stuck;
        w_arrival   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = ST_QUALIFY;
                    w_deb_nxt   = 4'd1;
                end
            end

            ST_QUALIFY: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                    w_deb_nxt   = 4'd0;
                end else if (r_deb == DEB_LAST) begin
                    w_state_nxt = ST_PRESENT;
                    w_deb_nxt   = 4'd0;
                    w_stuck_nxt = 16'd0;
                    w_arrival   = 1'b1;
                end else begin
                    w_deb_nxt = r_deb + 4'd1;
                end
            end

            ST_PRESENT: begin
                if (!w_s) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = 8'd1;
                end else if (r_stuck == STUCK_LAST) begin
                    // Continuous occupancy this long means the loop is
                    // stuck; keep demanding green as the fail-safe choice.
                    w_state_nxt = ST_FAULT;
                    w_deb_nxt   = 4'd0;
                end else begin
                    w_stuck_nxt = r_stuck + 16'd1;
                end
            end

            ST_HOLD: begin
                if (w_s) begin
                    // Same vehicle came back over the loop: no new arrival,
                    // but the occupancy timer starts over.
                    w_state_nxt = ST_PRESENT;
                    w_stuck_nxt = 16'd0;
                end else if (r_hold == HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = 8'd0;
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end

            ST_FAULT: begin
                // Recovery needs a debounced quiet period; any high sample
                // restarts it. Exit goes straight to IDLE with no hold.
                if (w_s) begin
                    w_deb_nxt = 4'd0;
                end else if (r_deb == DEB_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_deb_nxt   = 4'd0;
                end else begin
                    w_deb_nxt = r_deb + 4'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_deb_nxt   = 4'd0;
                w_hold_nxt  = 8'd0;
                w_stuck_nxt = 16'd0;
            end
        endcase
    end

    // Arrival counter: the clear wins over a coincident arrival, and the
    // count sticks at 255 instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_cnt_clr) begin
            r_count <= 8'd0;
        end else if (w_arrival && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Outputs are pure decodes of registered state, so they are glitch-free
    // with respect to the raw input and fall with reset without a clock.
    assign o_sensor = (r_state == ST_PRESENT) || (r_state == ST_HOLD) ||
                      (r_state == ST_FAULT);
    assign o_fault  = (r_state == ST_FAULT);
    assign o_count  = r_count;

endmodule

// -----------------------------------------------------------------------------
// Top level: two independent channels with a shared counter clear.
// -----------------------------------------------------------------------------
module vehicle_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int STUCK_CYCLES    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       main_loop_raw,
    input  logic       side_loop_raw,
    input  logic       cnt_clr,
    output logic       main_sensor,
    output logic       side_sensor,
    output logic       main_fault,
    output logic       side_fault,
    output logic [7:0] main_count,
    output logic [7:0] side_count
);

    vsc_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .i_raw     (main_loop_raw),
        .i_cnt_clr (cnt_clr),
        .o_sensor  (main_sensor),
        .o_fault   (main_fault),
        .o_count   (main_count)
    );

    vsc_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_side (
        .clk       (clk),
        .rst       (rst),
        .i_raw     (side_loop_raw),
        .i_cnt_clr (cnt_clr),
        .o_sensor  (side_sensor),
        .o_fault   (side_fault),
        .o_count   (side_count)
    );

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// tb_vehicle_sensor_conditioner
//
// Directed scenarios with hard-coded edge timings, followed by a long run of
// random loop activity, all compared every cycle against a run-length model
// of each channel (consecutive high/low sample counts rather than a state
// machine).
// -----------------------------------------------------------------------------
module tb_vehicle_sensor_conditioner;

    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int STUCK = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       main_loop_raw = 1'b0;
    logic       side_loop_raw = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       main_sensor;
    logic       side_sensor;
    logic       main_fault;
    logic       side_fault;
    logic [7:0] main_count;
    logic [7:0] side_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    vehicle_sensor_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .STUCK_CYCLES    (STUCK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .main_loop_raw (main_loop_raw),
        .side_loop_raw (side_loop_raw),
        .cnt_clr       (cnt_clr),
        .main_sensor   (main_sensor),
        .side_sensor   (side_sensor),
        .main_fault    (main_fault),
        .side_fault    (side_fault),
        .main_count    (main_count),
        .side_count    (side_count)
    );

    // Reference model of one channel, described by run lengths of the
    // synchronized samples.
    typedef struct {
        bit s1;         // raw seen at the previous edge
        bit s2;         // raw seen two edges ago: what the conditioner acts on
        int high_run;   // consecutive high samples up to and including now
        int low_run;    // consecutive low samples up to and including now
        int entry_run;  // high_run at the moment demand (re)started
        bit sensor;
        bit fault;
        int count;
    } chan_model_t;

    chan_model_t m_main;
    chan_model_t m_side;

    function automatic chan_model_t model_reset();
        chan_model_t m;
        m.s1 = 0; m.s2 = 0;
        m.high_run = 0; m.low_run = 0; m.entry_run = 0;
        m.sensor = 0; m.fault = 0; m.count = 0;
        return m;
    endfunction

    function automatic chan_model_t model_step(input chan_model_t m_in,
                                               input logic raw,
                                               input logic clr);
        chan_model_t m;
        bit s;
        bit arrival;
        m = m_in;
        arrival = 0;
        s = m.s2;
        m.s2 = m.s1;
        m.s1 = raw;
        if (s) begin
            m.high_run++;
            m.low_run = 0;
        end else begin
            m.low_run++;
            m.high_run = 0;
        end

        if (m.fault) begin
            // Clears after DEB quiet samples, straight to no demand.
            if (m.low_run == DEB) begin
                m.fault  = 0;
                m.sensor = 0;
            end
        end else if (m.sensor) begin
            if (s) begin
                if (m.high_run == 1)
                    m.entry_run = 1;               // back from hold
                else if (m.high_run - m.entry_run == STUCK)
                    m.fault = 1;                   // occupied STUCK cycles
            end else if (m.low_run == HOLD + 1) begin
                // first low sample starts the hold, HOLD more end it
                m.sensor = 0;
            end
        end else if (s && m.high_run == DEB) begin
            m.sensor    = 1;
            m.entry_run = DEB;
            arrival     = 1;
        end

        if (clr)
            m.count = 0;
        else if (arrival && m.count < 255)
            m.count++;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d expected %0d at t=%0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic compare_all();
        check("main_sensor", 32'(main_sensor), 32'(m_main.sensor));
        check("main_fault",  32'(main_fault),  32'(m_main.fault));
        check("main_count",  32'(main_count),  m_main.count);
        check("side_sensor", 32'(side_sensor), 32'(m_side.sensor));
        check("side_fault",  32'(side_fault),  32'(m_side.fault));
        check("side_count",  32'(side_count),  m_side.count);
    endtask

    // One clock: drive inputs, take the edge, advance the model, then sample
    // the DUT 1 ns after the edge.
    task automatic cycle(input logic raw_m, input logic raw_s, input logic clr);
        main_loop_raw = raw_m;
        side_loop_raw = raw_s;
        cnt_clr       = clr;
        @(posedge clk);
        m_main = model_step(m_main, raw_m, clr);
        m_side = model_step(m_side, raw_s, clr);
        #1;
        compare_all();
    endtask

    // Raise rst between clock edges, confirm outputs clear with no edge,
    // hold it across two edges, and release it between edges. The next
    // cycle() call is edge 0 of the new epoch.
    task automatic async_reset(input logic raw_m, input logic raw_s);
        #2;
        main_loop_raw = raw_m;
        side_loop_raw = raw_s;
        cnt_clr       = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_main_sensor", 32'(main_sensor), 32'd0);
        check("rst_main_fault",  32'(main_fault),  32'd0);
        check("rst_main_count",  32'(main_count),  32'd0);
        check("rst_side_sensor", 32'(side_sensor), 32'd0);
        check("rst_side_fault",  32'(side_fault),  32'd0);
        check("rst_side_count",  32'(side_count),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_main = model_reset();
        m_side = model_reset();
    endtask

    function automatic int pick_len();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 55)      return int'($urandom_range(1, 6));
        else if (r < 90) return int'($urandom_range(7, 30));
        else             return int'($urandom_range(150, 260));
    endfunction

    initial begin
        m_main = model_reset();
        m_side = model_reset();

        // Scenario A: arrival at edge 5, departure at edge 20, hold to edge 30.
        async_reset(1'b0, 1'b0);
        for (int e = 0; e <= 34; e++) begin
            cycle(logic'(e < 20), 1'b0, 1'b0);
            if (e == 4) check("a_rise_e4", 32'(main_sensor), 32'd0);
            if (e == 5) begin
                check("a_rise_e5",   32'(main_sensor), 32'd1);
                check("a_count",     32'(main_count),  32'd1);
                check("a_side_sens", 32'(side_sensor), 32'd0);
                check("a_side_cnt",  32'(side_count),  32'd0);
            end
            if (e == 29) check("a_hold_e29", 32'(main_sensor), 32'd1);
            if (e == 30) check("a_hold_e30", 32'(main_sensor), 32'd0);
        end

        // Scenario B: vehicle returns at edge 25, inside the hold window.
        async_reset(1'b0, 1'b0);
        for (int e = 0; e <= 44; e++) begin
            cycle(logic'((e < 20) || (e >= 25 && e < 35)), 1'b0, 1'b0);
            if (e >= 5) check("b_bridge", 32'(main_sensor), 32'd1);
        end
        check("b_count", 32'(main_count), 32'd1);
        for (int e = 0; e < 4; e++) cycle(1'b0, 1'b0, 1'b0);

        // Scenario C: 3-edge glitch never qualifies.
        async_reset(1'b0, 1'b0);
        for (int e = 0; e <= 14; e++) begin
            cycle(logic'(e < 3), logic'(e < 3), 1'b0);
            check("c_glitch", 32'(main_sensor), 32'd0);
        end
        check("c_count", 32'(main_count), 32'd0);

        // Scenario D: stuck loop for 300 edges.
        async_reset(1'b0, 1'b0);
        for (int e = 0; e <= 320; e++) begin
            cycle(logic'(e < 300), 1'b0, 1'b0);
            if (e == 204) check("d_fault_e204", 32'(main_fault), 32'd0);
            if (e == 205) begin
                check("d_fault_e205",  32'(main_fault),  32'd1);
                check("d_sensor_e205", 32'(main_sensor), 32'd1);
            end
            if (e == 304) check("d_fault_e304", 32'(main_fault), 32'd1);
            if (e == 305) begin
                check("d_fault_e305",  32'(main_fault),  32'd0);
                check("d_sensor_e305", 32'(main_sensor), 32'd0);
            end
        end

        // Scenario E: 256 arrivals saturate, then clear beats an arrival.
        async_reset(1'b0, 1'b0);
        for (int k = 0; k < 256; k++) begin
            int hi;
            int lo;
            hi = 4 + int'($urandom_range(0, 3));
            lo = 12 + int'($urandom_range(0, 5));
            for (int e = 0; e < hi; e++) cycle(1'b1, 1'b0, 1'b0);
            for (int e = 0; e < lo; e++) cycle(1'b0, 1'b0, 1'b0);
            if (k == 254) check("e_count_255", 32'(main_count), 32'd255);
        end
        check("e_count_sat", 32'(main_count), 32'd255);
        for (int e = 0; e <= 7; e++) begin
            cycle(1'b1, 1'b0, logic'(e == 5));
            if (e == 5) begin
                check("e_clr_count",  32'(main_count),  32'd0);
                check("e_clr_sensor", 32'(main_sensor), 32'd1);
            end
        end

        // Scenario F: reset mid-PRESENT with the loop still occupied.
        async_reset(1'b0, 1'b0);
        for (int e = 0; e <= 11; e++) cycle(1'b1, 1'b1, 1'b0);
        check("f_pre_sensor", 32'(main_sensor), 32'd1);
        async_reset(1'b1, 1'b1);
        for (int e = 0; e <= 7; e++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (e == 4) check("f_rise_e4", 32'(main_sensor), 32'd0);
            if (e == 5) begin
                check("f_rise_e5", 32'(main_sensor), 32'd1);
                check("f_count",   32'(main_count),  32'd1);
            end
        end

        // Random activity on both loops with occasional clears and resets.
        begin
            int   len_m = 0;
            int   len_s = 0;
            logic lvl_m = 1'b1;
            logic lvl_s = 1'b1;
            for (int c = 0; c < 25000; c++) begin
                if (len_m == 0) begin
                    lvl_m = ~lvl_m;
                    len_m = pick_len();
                end
                if (len_s == 0) begin
                    lvl_s = ~lvl_s;
                    len_s = pick_len();
                end
                if ($urandom_range(0, 2999) == 0) async_reset(lvl_m, lvl_s);
                cycle(lvl_m, lvl_s, logic'($urandom_range(0, 199) == 0));
                len_m--;
                len_s--;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
